// File: rtl/chdr_ramp_pkt_checker_if.sv
// AXI-Stream beat channel carrying 64-bit CHDR words into the ramp packet checker.
// The producer uses the master modport; the checker consumes through the slave modport.
interface chdr_ramp_pkt_checker_if;
    logic [63:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;

    modport master (output i_tdata, output i_tlast, output i_tvalid, input i_tready);
    modport slave  (input i_tdata, input i_tlast, input i_tvalid, output i_tready);
endinterface

// File: rtl/chdr_ramp_pkt_checker.sv
// Sink for CHDR ramp packets: checks header length, SID, sequence and ramp payload,
// and keeps saturating packet/error counters readable over a small readback mux.
module chdr_ramp_pkt_checker #(
    parameter int SR_BASE   = 0,
    parameter int SR_AWIDTH = 8
) (
    input  logic                   bus_clk,
    input  logic                   bus_rst_n,
    input  logic                   set_stb,
    input  logic [SR_AWIDTH-1:0]   set_addr,
    input  logic [31:0]            set_data,
    chdr_ramp_pkt_checker_if.slave axis,
    output logic                   pkt_done,
    output logic                   pkt_err,
    output logic [4:0]             err_flags,
    input  logic [1:0]             rb_addr,
    output logic [63:0]            rb_data
);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_TIME = 2'd1,
        S_PAY  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [SR_AWIDTH-1:0] ADDR_CTRL = SR_AWIDTH'(SR_BASE);
    localparam logic [SR_AWIDTH-1:0] ADDR_SID  = SR_AWIDTH'(SR_BASE + 1);
    localparam logic [SR_AWIDTH-1:0] ADDR_STEP = SR_AWIDTH'(SR_BASE + 2);
    localparam logic [SR_AWIDTH-1:0] ADDR_LEN  = SR_AWIDTH'(SR_BASE + 3);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    state_t        state_q, state_d;
    logic          tready_q, tready_d;
    logic          enable_q, enable_d;
    logic          check_sid_q, check_seq_q;
    logic [31:0]   exp_sid_q, ramp_step_q;
    logic [15:0]   exp_len_q;

    logic          has_time_q;
    logic [11:0]   seq_q;
    logic [15:0]   len_q;
    logic [31:0]   sid_q;
    logic [63:0]   ramp_q;
    logic [31:0]   word_cnt_q;
    logic          pay_err_q;

    logic          pkt_done_q, pkt_err_q;
    logic [4:0]    err_flags_q;
    logic [31:0]   pkt_cnt_q, err_pkt_cnt_q, word_err_cnt_q;
    logic [11:0]   last_seq_q;
    logic          seq_valid_q;
    logic [15:0]   last_words_q;
    logic [63:0]   rb_q;

    logic          wr_ctrl_s, wr_sid_s, wr_step_s, wr_len_s, clear_s;
    logic          hs_s, last_hs_s, in_hdr_s, pay_beat_s, mismatch_s;
    logic          cur_has_time_s;
    logic [11:0]   cur_seq_s;
    logic [15:0]   cur_len_s;
    logic [31:0]   cur_sid_s;
    logic [31:0]   words_fin_s;
    logic          pay_err_fin_s;
    logic [32:0]   beats_s;
    logic [16:0]   len_beats_s;
    logic [4:0]    flags_s;
    logic          unused_s;

    assign wr_ctrl_s = set_stb && (set_addr == ADDR_CTRL);
    assign wr_sid_s  = set_stb && (set_addr == ADDR_SID);
    assign wr_step_s = set_stb && (set_addr == ADDR_STEP);
    assign wr_len_s  = set_stb && (set_addr == ADDR_LEN);
    assign clear_s   = wr_ctrl_s && set_data[1];
    assign enable_d  = wr_ctrl_s ? set_data[0] : enable_q;

    assign hs_s       = axis.i_tvalid && tready_q;
    assign last_hs_s  = hs_s && axis.i_tlast;
    assign in_hdr_s   = (state_q == S_HDR);
    assign pay_beat_s = hs_s && (state_q == S_PAY);
    assign mismatch_s = pay_beat_s && (axis.i_tdata != ramp_q);

    assign unused_s = ^{axis.i_tdata[63:62], axis.i_tdata[60]};

    // Settings registers; the clear bit is a pulse and is never stored.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            enable_q    <= 1'b0;
            check_sid_q <= 1'b0;
            check_seq_q <= 1'b0;
            exp_sid_q   <= 32'd0;
            ramp_step_q <= 32'd0;
            exp_len_q   <= 16'd0;
        end else begin
            enable_q <= enable_d;
            if (wr_ctrl_s) begin
                check_sid_q <= set_data[2];
                check_seq_q <= set_data[3];
            end
            if (wr_sid_s)  exp_sid_q   <= set_data;
            if (wr_step_s) ramp_step_q <= set_data;
            if (wr_len_s)  exp_len_q   <= set_data[15:0];
        end
    end

    // FSM state register; tready is registered from the next state.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state_q  <= S_HDR;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tready_q <= tready_d;
        end
    end

    // FSM next-state and next tready; a started packet is always drained.
    always_comb begin
        state_d  = state_q;
        tready_d = 1'b0;
        case (state_q)
            S_HDR: begin
                if (hs_s) begin
                    if (axis.i_tlast)          state_d = S_DONE;
                    else if (axis.i_tdata[61]) state_d = S_TIME;
                    else                       state_d = S_PAY;
                end else begin
                    state_d = S_HDR;
                end
            end
            S_TIME: begin
                if (hs_s) state_d = axis.i_tlast ? S_DONE : S_PAY;
                else      state_d = S_TIME;
            end
            S_PAY: begin
                if (last_hs_s) state_d = S_DONE;
                else           state_d = S_PAY;
            end
            S_DONE:  state_d = S_HDR;
            default: state_d = S_HDR;
        endcase
        case (state_d)
            S_HDR:   tready_d = enable_d;
            S_TIME:  tready_d = 1'b1;
            S_PAY:   tready_d = 1'b1;
            default: tready_d = 1'b0;
        endcase
    end

    // Final-beat view of the packet, so flags can be registered on the tlast edge.
    always_comb begin
        cur_has_time_s = has_time_q;
        cur_seq_s      = seq_q;
        cur_len_s      = len_q;
        cur_sid_s      = sid_q;
        words_fin_s    = 32'd0;
        pay_err_fin_s  = 1'b0;
        if (in_hdr_s) begin
            cur_has_time_s = axis.i_tdata[61];
            cur_seq_s      = axis.i_tdata[59:48];
            cur_len_s      = axis.i_tdata[47:32];
            cur_sid_s      = axis.i_tdata[31:0];
        end else begin
            words_fin_s   = pay_beat_s ? sat_inc(word_cnt_q) : word_cnt_q;
            pay_err_fin_s = pay_err_q || mismatch_s;
        end
        beats_s     = 33'd1 + {32'd0, cur_has_time_s} + {1'b0, words_fin_s};
        len_beats_s = ({1'b0, cur_len_s} + 17'd7) >> 2'd3;
        flags_s[0]  = ({16'd0, len_beats_s} != beats_s);
        flags_s[1]  = (exp_len_q != 16'd0) && (words_fin_s != {16'd0, exp_len_q});
        flags_s[2]  = check_sid_q && (cur_sid_s != exp_sid_q);
        flags_s[3]  = check_seq_q && seq_valid_q && (cur_seq_s != (last_seq_q + 12'd1));
        flags_s[4]  = pay_err_fin_s;
    end

    // Per-packet capture: header fields, running ramp and payload word count.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            has_time_q <= 1'b0;
            seq_q      <= 12'd0;
            len_q      <= 16'd0;
            sid_q      <= 32'd0;
            ramp_q     <= 64'd0;
            word_cnt_q <= 32'd0;
            pay_err_q  <= 1'b0;
        end else if (hs_s && in_hdr_s) begin
            has_time_q <= axis.i_tdata[61];
            seq_q      <= axis.i_tdata[59:48];
            len_q      <= axis.i_tdata[47:32];
            sid_q      <= axis.i_tdata[31:0];
            ramp_q     <= 64'd0;
            word_cnt_q <= 32'd0;
            pay_err_q  <= 1'b0;
        end else if (pay_beat_s) begin
            ramp_q     <= ramp_q + {32'd0, ramp_step_q};
            word_cnt_q <= sat_inc(word_cnt_q);
            pay_err_q  <= pay_err_q || mismatch_s;
        end else begin
            ramp_q <= ramp_q;
        end
    end

    // Packet results and counters; a clear on the same edge takes priority.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            pkt_done_q    <= 1'b0;
            pkt_err_q     <= 1'b0;
            err_flags_q   <= 5'd0;
            pkt_cnt_q     <= 32'd0;
            err_pkt_cnt_q <= 32'd0;
            last_seq_q    <= 12'd0;
            seq_valid_q   <= 1'b0;
            last_words_q  <= 16'd0;
        end else begin
            pkt_done_q <= last_hs_s;
            pkt_err_q  <= last_hs_s && (|flags_s) && !clear_s;
            if (clear_s) begin
                err_flags_q   <= 5'd0;
                pkt_cnt_q     <= 32'd0;
                err_pkt_cnt_q <= 32'd0;
                last_seq_q    <= 12'd0;
                seq_valid_q   <= 1'b0;
                last_words_q  <= 16'd0;
            end else if (last_hs_s) begin
                err_flags_q  <= flags_s;
                pkt_cnt_q    <= sat_inc(pkt_cnt_q);
                if (|flags_s) err_pkt_cnt_q <= sat_inc(err_pkt_cnt_q);
                last_seq_q   <= cur_seq_s;
                seq_valid_q  <= 1'b1;
                last_words_q <= words_fin_s[15:0];
            end else begin
                err_flags_q <= err_flags_q;
            end
        end
    end

    // Ramp word mismatch counter, advanced per payload beat.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n)      word_err_cnt_q <= 32'd0;
        else if (clear_s)    word_err_cnt_q <= 32'd0;
        else if (mismatch_s) word_err_cnt_q <= sat_inc(word_err_cnt_q);
        else                 word_err_cnt_q <= word_err_cnt_q;
    end

    // Registered readback mux.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            rb_q <= 64'd0;
        end else begin
            case (rb_addr)
                2'd0:    rb_q <= {32'd0, pkt_cnt_q};
                2'd1:    rb_q <= {32'd0, err_pkt_cnt_q};
                2'd2:    rb_q <= {27'd0, err_flags_q, last_seq_q, last_words_q, 4'd0};
                2'd3:    rb_q <= {32'd0, word_err_cnt_q};
                default: rb_q <= 64'd0;
            endcase
        end
    end

    assign axis.i_tready = tready_q;
    assign pkt_done      = pkt_done_q;
    assign pkt_err       = pkt_err_q;
    assign err_flags     = err_flags_q;
    assign rb_data       = rb_q;

endmodule

// File: tb/tb_chdr_ramp_pkt_checker.sv
// Randomized bench for chdr_ramp_pkt_checker with a packet-level reference model
// (ramp words computed as index*step, flags from whole-packet arithmetic).
module tb_chdr_ramp_pkt_checker;

    logic        bus_clk = 1'b0;
    logic        bus_rst_n;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic        pkt_done, pkt_err;
    logic [4:0]  err_flags;
    logic [1:0]  rb_addr;
    logic [63:0] rb_data;

    chdr_ramp_pkt_checker_if axis();

    chdr_ramp_pkt_checker #(.SR_BASE(0), .SR_AWIDTH(8)) u_dut (
        .bus_clk   (bus_clk),
        .bus_rst_n (bus_rst_n),
        .set_stb   (set_stb),
        .set_addr  (set_addr),
        .set_data  (set_data),
        .axis      (axis),
        .pkt_done  (pkt_done),
        .pkt_err   (pkt_err),
        .err_flags (err_flags),
        .rb_addr   (rb_addr),
        .rb_data   (rb_data)
    );

    always #5 bus_clk = ~bus_clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // reference model state
    logic [31:0]     m_step, m_exp_sid;
    logic [15:0]     m_exp_len;
    bit              m_chk_sid, m_chk_seq, m_seq_valid;
    logic [11:0]     m_prev_seq;
    logic [15:0]     m_last_words;
    logic [4:0]      m_flags;
    longint unsigned m_pkt, m_errpkt, m_werr;

    // current packet description
    bit          p_ht;
    logic [11:0] p_seq;
    logic [15:0] p_len;
    logic [31:0] p_sid;
    logic [63:0] p_pay[$];
    logic [63:0] p_beats[$];
    logic [63:0] rd;

    function automatic logic [63:0] ramp_word(int unsigned i);
        return 64'(i) * {32'h0, m_step};
    endfunction

    task automatic model_clear();
        m_pkt = 0; m_errpkt = 0; m_werr = 0;
        m_seq_valid = 1'b0; m_prev_seq = 12'd0; m_last_words = 16'd0; m_flags = 5'd0;
    endtask

    task automatic model_pkt();
        int nw, beats, mm;
        nw = p_pay.size();
        beats = 1 + int'(p_ht) + nw;
        mm = 0;
        for (int i = 0; i < nw; i++) if (p_pay[i] != ramp_word(i)) mm++;
        m_flags[0] = ((int'(p_len) + 7) / 8) != beats;
        m_flags[1] = (m_exp_len != 16'd0) && (nw != int'(m_exp_len));
        m_flags[2] = m_chk_sid && (p_sid != m_exp_sid);
        m_flags[3] = m_chk_seq && m_seq_valid && (int'(p_seq) != (int'(m_prev_seq) + 1) % 4096);
        m_flags[4] = (mm != 0);
        m_prev_seq = p_seq; m_seq_valid = 1'b1; m_last_words = 16'(nw);
        if (m_pkt < 64'hFFFF_FFFF) m_pkt++;
        if (m_flags != 5'd0 && m_errpkt < 64'hFFFF_FFFF) m_errpkt++;
        m_werr = m_werr + longint'(mm);
        if (m_werr > 64'hFFFF_FFFF) m_werr = 64'hFFFF_FFFF;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge bus_clk);
        set_stb = 1'b1; set_addr = {6'd0, a}; set_data = d;
        @(negedge bus_clk);
        set_stb = 1'b0;
        case (a)
            2'd0: begin m_chk_sid = d[2]; m_chk_seq = d[3]; if (d[1]) model_clear(); end
            2'd1: m_exp_sid = d;
            2'd2: m_step = d;
            default: m_exp_len = d[15:0];
        endcase
    endtask

    task automatic read_rb(input logic [1:0] a, output logic [63:0] v);
        @(negedge bus_clk);
        rb_addr = a;
        @(negedge bus_clk);
        v = rb_data;
    endtask

    task automatic set_pkt(input bit ht, input logic [11:0] seq, input logic [31:0] sid, input int n);
        p_ht = ht; p_seq = seq; p_sid = sid;
        p_pay.delete();
        for (int i = 0; i < n; i++) p_pay.push_back(ramp_word(i));
        p_len = 16'(8 * (1 + int'(ht) + n));
    endtask

    task automatic build_pkt();
        p_beats.delete();
        p_beats.push_back({2'b00, p_ht, 1'b0, p_seq, p_len, p_sid});
        if (p_ht) p_beats.push_back({$urandom, $urandom});
        foreach (p_pay[i]) p_beats.push_back(p_pay[i]);
    endtask

    // Drives p_beats; returns at the negedge one cycle after the tlast handshake.
    task automatic send_pkt(input bit bp, input int ctrl_beat, input logic [31:0] ctrl_val);
        int idx, cyc;
        bit acc, wrote;
        idx = 0; cyc = 0; wrote = 1'b0;
        while (idx < p_beats.size() && cyc < 4000) begin
            @(negedge bus_clk);
            set_stb = 1'b0;
            axis.i_tvalid = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            axis.i_tdata  = p_beats[idx];
            axis.i_tlast  = (idx == p_beats.size() - 1);
            if (!wrote && idx == ctrl_beat) begin
                set_stb = 1'b1; set_addr = 8'd0; set_data = ctrl_val; wrote = 1'b1;
            end
            #4;
            acc = axis.i_tvalid && axis.i_tready;
            @(posedge bus_clk);
            if (acc) idx++;
            cyc++;
        end
        @(negedge bus_clk);
        axis.i_tvalid = 1'b0; axis.i_tlast = 1'b0; set_stb = 1'b0;
        n_checks++;
        if (idx != p_beats.size()) begin
            n_fail++;
            $display("FAIL send_timeout: beats accepted %0d, required %0d", idx, p_beats.size());
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({axis.i_tready, pkt_done, pkt_err, err_flags} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 0", {axis.i_tready, pkt_done, pkt_err, err_flags});
        end
        n_checks++;
        if (rb_data !== 64'd0) begin
            n_fail++; $display("FAIL reset_rb_data: got %h, required 0", rb_data);
        end
        for (int a = 0; a < 4; a++) begin
            read_rb(2'(a), rd);
            n_checks++;
            if (rd !== 64'd0) begin
                n_fail++; $display("FAIL reset_rb%0d: got %h, required 0", a, rd);
            end
        end
    endtask

    task automatic test_clean();
        write_reg(2'd1, 32'h1234);
        write_reg(2'd2, 32'h100);
        write_reg(2'd3, 32'd16);
        write_reg(2'd0, 32'hD);
        set_pkt(1'b0, 12'h666, 32'h1234, 16);
        build_pkt();
        send_pkt(1'b0, -1, 32'd0);
        model_pkt();
        n_checks++;
        if ({pkt_done, pkt_err, err_flags} !== 7'b1000000) begin
            n_fail++; $display("FAIL clean_result: done/err/flags %b, required 1000000", {pkt_done, pkt_err, err_flags});
        end
        n_checks++;
        if (axis.i_tready !== 1'b0) begin
            n_fail++; $display("FAIL clean_done_tready: got %b, required 0", axis.i_tready);
        end
        read_rb(2'd0, rd);
        n_checks++;
        if (rd !== 64'd1) begin
            n_fail++; $display("FAIL clean_pkt_count: got %h, required 1", rd);
        end
        read_rb(2'd2, rd);
        n_checks++;
        if (rd !== {27'd0, 5'd0, 12'h666, 16'd16, 4'd0}) begin
            n_fail++; $display("FAIL clean_rb2: got %h, required %h", rd, {27'd0, 5'd0, 12'h666, 16'd16, 4'd0});
        end
    endtask

    task automatic test_timestamp();
        set_pkt(1'b1, m_prev_seq + 12'd1, 32'h1234, 16);
        build_pkt(); send_pkt(1'b0, -1, 32'd0); model_pkt();
        n_checks++;
        if ({pkt_done, err_flags} !== 6'b100000) begin
            n_fail++; $display("FAIL ts_16: done/flags %b, required 100000", {pkt_done, err_flags});
        end
        set_pkt(1'b1, m_prev_seq + 12'd1, 32'h1234, 20);
        p_len = 16'd144;
        build_pkt(); send_pkt(1'b0, -1, 32'd0); model_pkt();
        n_checks++;
        if ({pkt_done, pkt_err, err_flags} !== 7'b1100011) begin
            n_fail++; $display("FAIL ts_20: done/err/flags %b, required 1100011", {pkt_done, pkt_err, err_flags});
        end
    endtask

    task automatic test_bad_data_sid();
        write_reg(2'd0, 32'hF);
        set_pkt(1'b0, 12'h100, 32'h1235, 16);
        p_pay[5] = p_pay[5] ^ 64'h1;
        build_pkt(); send_pkt(1'b0, -1, 32'd0); model_pkt();
        n_checks++;
        if ({pkt_err, err_flags} !== 6'b110100) begin
            n_fail++; $display("FAIL bad_flags: err/flags %b, required 110100", {pkt_err, err_flags});
        end
        read_rb(2'd3, rd);
        n_checks++;
        if (rd !== 64'd1) begin
            n_fail++; $display("FAIL bad_word_err_count: got %h, required 1", rd);
        end
        read_rb(2'd1, rd);
        n_checks++;
        if (rd !== 64'd1) begin
            n_fail++; $display("FAIL bad_err_pkt_count: got %h, required 1", rd);
        end
    endtask

    task automatic test_seq();
        logic [11:0] seqs [3];
        logic        want [3];
        seqs = '{12'hFFF, 12'h000, 12'h002};
        want = '{1'b0, 1'b0, 1'b1};
        write_reg(2'd0, 32'hF);
        for (int k = 0; k < 3; k++) begin
            set_pkt(1'b0, seqs[k], 32'h1234, 16);
            build_pkt(); send_pkt(1'b0, -1, 32'd0); model_pkt();
            n_checks++;
            if (err_flags[3] !== want[k] || err_flags !== m_flags) begin
                n_fail++;
                $display("FAIL seq_%0d: flags %b, required %b (seq bit %b)", k, err_flags, m_flags, want[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        write_reg(2'd2, $urandom);
        write_reg(2'd3, 32'd20);
        write_reg(2'd0, 32'hF);
        for (int k = 0; k < 10; k++) begin
            set_pkt(1'(k % 2), 12'($urandom), 32'h1234, 20);
            if (m_seq_valid) p_seq = m_prev_seq + 12'd1;
            build_pkt(); send_pkt(1'b1, -1, 32'd0); model_pkt();
            n_checks++;
            if ({pkt_done, pkt_err, err_flags} !== 7'b1000000) begin
                n_fail++; $display("FAIL bp_pkt%0d: done/err/flags %b, required 1000000", k, {pkt_done, pkt_err, err_flags});
            end
        end
        read_rb(2'd0, rd);
        n_checks++;
        if (rd !== 64'd10) begin
            n_fail++; $display("FAIL bp_pkt_count: got %h, required 10", rd);
        end
        read_rb(2'd1, rd);
        n_checks++;
        if (rd !== 64'd0) begin
            n_fail++; $display("FAIL bp_err_pkt_count: got %h, required 0", rd);
        end
    endtask

    task automatic test_enable_drop();
        set_pkt(1'b0, m_prev_seq + 12'd1, 32'h1234, 12);
        p_len = 16'(8 * 13);
        build_pkt();
        send_pkt(1'b0, 5, 32'hC);
        model_pkt();
        n_checks++;
        if ({pkt_done, err_flags} !== {1'b1, m_flags}) begin
            n_fail++; $display("FAIL drop_complete: done/flags %b, required %b", {pkt_done, err_flags}, {1'b1, m_flags});
        end
        for (int c = 0; c < 4; c++) begin
            axis.i_tvalid = 1'b1; axis.i_tdata = 64'd0; axis.i_tlast = 1'b1;
            @(negedge bus_clk);
            n_checks++;
            if (axis.i_tready !== 1'b0 || pkt_done !== 1'b0) begin
                n_fail++; $display("FAIL drop_idle%0d: tready %b done %b, required 0 0", c, axis.i_tready, pkt_done);
            end
        end
        axis.i_tvalid = 1'b0; axis.i_tlast = 1'b0;
    endtask

    task automatic test_clear_in_done();
        write_reg(2'd0, 32'hD);
        set_pkt(1'b0, 12'h7AB, 32'h1234, 20);
        build_pkt(); send_pkt(1'b0, -1, 32'd0); model_pkt();
        set_stb = 1'b1; set_addr = 8'd0; set_data = 32'hF;
        model_clear();
        @(negedge bus_clk);
        set_stb = 1'b0;
        for (int a = 0; a < 4; a++) begin
            read_rb(2'(a), rd);
            n_checks++;
            if (rd !== 64'd0) begin
                n_fail++; $display("FAIL clear_rb%0d: got %h, required 0", a, rd);
            end
        end
        set_pkt(1'b0, 12'h123, 32'h1234, 20);
        build_pkt(); send_pkt(1'b0, -1, 32'd0); model_pkt();
        n_checks++;
        if (err_flags !== 5'd0) begin
            n_fail++; $display("FAIL clear_no_history: flags %b, required 00000", err_flags);
        end
    endtask

    task automatic test_random();
        int n;
        write_reg(2'd1, $urandom);
        write_reg(2'd2, $urandom);
        write_reg(2'd3, 32'd12);
        write_reg(2'd0, 32'hD);
        for (int k = 0; k < 14; k++) begin
            n = $urandom_range(1, 24);
            set_pkt(1'($urandom_range(0, 1)), 12'($urandom), m_exp_sid, n);
            if (m_seq_valid && $urandom_range(0, 3) != 0) p_seq = m_prev_seq + 12'd1;
            if ($urandom_range(0, 3) == 0) p_sid = $urandom;
            if ($urandom_range(0, 3) == 0) p_len = p_len + 16'(8 * $urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) begin
                int j;
                j = $urandom_range(0, n - 1);
                p_pay[j] = p_pay[j] ^ ({32'd0, $urandom} | 64'h1);
            end
            build_pkt(); send_pkt(1'($urandom_range(0, 1)), -1, 32'd0); model_pkt();
            n_checks++;
            if ({pkt_done, pkt_err, err_flags} !== {1'b1, |m_flags, m_flags}) begin
                n_fail++;
                $display("FAIL rand_pkt%0d: done/err/flags %b, required %b", k, {pkt_done, pkt_err, err_flags}, {1'b1, |m_flags, m_flags});
            end
        end
        read_rb(2'd0, rd);
        n_checks++;
        if (rd !== {32'd0, 32'(m_pkt)}) begin n_fail++; $display("FAIL rand_rb0: got %h, required %h", rd, m_pkt); end
        read_rb(2'd1, rd);
        n_checks++;
        if (rd !== {32'd0, 32'(m_errpkt)}) begin n_fail++; $display("FAIL rand_rb1: got %h, required %h", rd, m_errpkt); end
        read_rb(2'd2, rd);
        n_checks++;
        if (rd !== {27'd0, m_flags, m_prev_seq, m_last_words, 4'd0}) begin
            n_fail++; $display("FAIL rand_rb2: got %h, required %h", rd, {27'd0, m_flags, m_prev_seq, m_last_words, 4'd0});
        end
        read_rb(2'd3, rd);
        n_checks++;
        if (rd !== {32'd0, 32'(m_werr)}) begin n_fail++; $display("FAIL rand_rb3: got %h, required %h", rd, m_werr); end
    endtask

    task automatic test_reset_mid_packet();
        set_pkt(1'b0, 12'h010, m_exp_sid, 8);
        build_pkt();
        for (int k = 0; k < 3; k++) begin
            @(negedge bus_clk);
            axis.i_tvalid = 1'b1; axis.i_tdata = p_beats[k]; axis.i_tlast = 1'b0;
        end
        @(negedge bus_clk);
        bus_rst_n = 1'b0; axis.i_tvalid = 1'b0;
        @(negedge bus_clk);
        n_checks++;
        if ({axis.i_tready, pkt_done, pkt_err, err_flags} !== 8'd0 || rb_data !== 64'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: %b rb %h, required all 0", {axis.i_tready, pkt_done, pkt_err, err_flags}, rb_data);
        end
        bus_rst_n = 1'b1;
        m_step = 32'd0; m_exp_sid = 32'd0; m_exp_len = 16'd0; m_chk_sid = 1'b0; m_chk_seq = 1'b0;
        model_clear();
        write_reg(2'd2, 32'h3);
        write_reg(2'd0, 32'h9);
        set_pkt(1'b0, 12'h020, 32'h0, 10);
        build_pkt(); send_pkt(1'b0, -1, 32'd0); model_pkt();
        n_checks++;
        if ({pkt_done, pkt_err, err_flags} !== 7'b1000000) begin
            n_fail++; $display("FAIL rst_mid_next_pkt: done/err/flags %b, required 1000000", {pkt_done, pkt_err, err_flags});
        end
        read_rb(2'd0, rd);
        n_checks++;
        if (rd !== 64'd1) begin n_fail++; $display("FAIL rst_mid_pkt_count: got %h, required 1", rd); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_rst_n = 1'b0; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0; rb_addr = 2'd0;
        axis.i_tvalid = 1'b0; axis.i_tdata = 64'd0; axis.i_tlast = 1'b0;
        m_step = 32'd0; m_exp_sid = 32'd0; m_exp_len = 16'd0; m_chk_sid = 1'b0; m_chk_seq = 1'b0;
        model_clear();
        repeat (3) @(negedge bus_clk);
        test_reset();
        bus_rst_n = 1'b1;
        test_reset();
        test_clean();
        test_timestamp();
        test_bad_data_sid();
        test_seq();
        test_backpressure();
        test_enable_drop();
        test_clear_in_done();
        test_random();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
